// File: rtl/pc_unit.sv
// Fetch program counter: sequential advance, JAL redirect, lock while a conditional
// branch resolves, ROB flush redirect, and a saturating lock-cycle counter.
module pc_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_stall,
  input  logic                  dec_valid,
  input  logic                  dec_is_branch,
  input  logic                  dec_is_jal,
  input  logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic [20:0]           dec_jal_offset,
  input  logic                  bra_done,
  input  logic                  bra_taken,
  input  logic [ADDR_WIDTH-1:0] bra_target,
  input  logic                  rob_flush,
  input  logic [ADDR_WIDTH-1:0] rob_flush_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_locked,
  output logic                  fetch_kill,
  output logic [CNT_WIDTH-1:0]  lock_cycles,
  output logic                  protocol_err
);

  typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] INSN_BYTES = ADDR_WIDTH'(4);

  state_t                state;
  logic [ADDR_WIDTH-1:0] fallthrough;

  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] dec_next;
  logic [ADDR_WIDTH-1:0] jal_sum;
  logic [ADDR_WIDTH-1:0] jal_target;
  logic [ADDR_WIDTH-1:0] flush_target;
  logic [ADDR_WIDTH-1:0] taken_target;
  logic                  accept;
  logic                  take_jal;
  logic                  take_branch;
  logic                  cnt_max;

  assign seq_pc       = pc + INSN_BYTES;
  assign dec_next     = dec_pc + INSN_BYTES;
  assign jal_sum      = dec_pc + {{(ADDR_WIDTH-21){dec_jal_offset[20]}}, dec_jal_offset};
  assign jal_target   = jal_sum & ALIGN_MASK;
  assign flush_target = rob_flush_pc & ALIGN_MASK;
  assign taken_target = bra_target & ALIGN_MASK;

  // Decoder is only honoured in RUN with the stall controller letting fetch move;
  // JAL outranks a simultaneous branch flag.
  assign accept      = dec_valid & ~pc_stall;
  assign take_jal    = accept & dec_is_jal;
  assign take_branch = accept & dec_is_branch & ~dec_is_jal;
  assign cnt_max     = &lock_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      fallthrough  <= RESET_PC;
      pc_locked    <= 1'b0;
      fetch_kill   <= 1'b0;
      lock_cycles  <= '0;
      protocol_err <= 1'b0;
    end else begin
      fetch_kill <= 1'b0;

      if (state == LOCK && !cnt_max)
        lock_cycles <= lock_cycles + CNT_WIDTH'(1);

      // A resolution arriving with no branch outstanding is a handshake bug upstream.
      if (state == RUN && bra_done && !rob_flush)
        protocol_err <= 1'b1;

      if (rob_flush) begin
        pc         <= flush_target;
        state      <= RUN;
        pc_locked  <= 1'b0;
        fetch_kill <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (take_jal) begin
              pc         <= jal_target;
              fetch_kill <= 1'b1;
            end else if (take_branch) begin
              fallthrough <= dec_next;
              pc          <= dec_next;
              state       <= LOCK;
              pc_locked   <= 1'b1;
            end else if (!pc_stall) begin
              pc <= seq_pc;
            end
          end
          LOCK: begin
            // Fetch was already frozen, so the redirect needs no kill pulse.
            if (bra_done) begin
              pc        <= bra_taken ? taken_target : fallthrough;
              state     <= RUN;
              pc_locked <= 1'b0;
            end
          end
          default: begin
            state     <= RUN;
            pc_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed plan followed by random traffic, every cycle compared with a behavioural model.
module tb_pc_unit;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_stall;
  logic        dec_valid;
  logic        dec_is_branch;
  logic        dec_is_jal;
  logic [31:0] dec_pc;
  logic [20:0] dec_jal_offset;
  logic        bra_done;
  logic        bra_taken;
  logic [31:0] bra_target;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;
  logic [31:0] pc;
  logic        pc_locked;
  logic        fetch_kill;
  logic [CW-1:0] lock_cycles;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit [31:0] m_pc, m_ft;
  bit        m_lock, m_kill, m_err;
  int        m_cnt;

  pc_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall),
    .dec_valid(dec_valid), .dec_is_branch(dec_is_branch), .dec_is_jal(dec_is_jal),
    .dec_pc(dec_pc), .dec_jal_offset(dec_jal_offset),
    .bra_done(bra_done), .bra_taken(bra_taken), .bra_target(bra_target),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc),
    .pc(pc), .pc_locked(pc_locked), .fetch_kill(fetch_kill),
    .lock_cycles(lock_cycles), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next state from the rules: flush beats resolution beats JAL beats lock beats advance.
  task automatic model_step();
    bit [31:0] npc;
    if (rst) begin
      m_pc = 32'h0; m_ft = 32'h0; m_lock = 0; m_kill = 0; m_cnt = 0; m_err = 0;
      return;
    end
    npc    = m_pc;
    m_kill = 0;
    if (m_lock) m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : (1 << CW) - 1;
    if (!m_lock && bra_done && !rob_flush) m_err = 1;
    if (rob_flush) begin
      npc = rob_flush_pc & 32'hFFFF_FFFC; m_lock = 0; m_kill = 1;
    end else if (m_lock) begin
      if (bra_done) begin
        npc    = bra_taken ? (bra_target & 32'hFFFF_FFFC) : m_ft;
        m_lock = 0;
      end
    end else if (!pc_stall) begin
      if (dec_valid && dec_is_jal) begin
        npc    = 32'(longint'(dec_pc) + longint'($signed(dec_jal_offset))) & 32'hFFFF_FFFC;
        m_kill = 1;
      end else if (dec_valid && dec_is_branch) begin
        npc = dec_pc + 32'd4; m_ft = npc; m_lock = 1;
      end else begin
        npc = m_pc + 32'd4;
      end
    end
    m_pc = npc;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("pc_locked", pc_locked, m_lock);
    chk("fetch_kill", fetch_kill, m_kill);
    chk("lock_cycles", lock_cycles, m_cnt);
    chk("protocol_err", protocol_err, m_err);
  endtask

  task automatic idle();
    rst = 0; pc_stall = 0; dec_valid = 0; dec_is_branch = 0; dec_is_jal = 0;
    dec_pc = '0; dec_jal_offset = '0; bra_done = 0; bra_taken = 0; bra_target = '0;
    rob_flush = 0; rob_flush_pc = '0;
  endtask

  task automatic branch_at(input logic [31:0] a);
    idle(); dec_valid = 1; dec_is_branch = 1; dec_pc = a; tick(); idle();
  endtask

  initial begin
    idle();
    // 1: reset then sequential advance
    rst = 1; tick(); tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_locked", pc_locked, 1'b0);
    idle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", pc, 32'(4 * i));
    end

    // 2: taken branch after three held cycles
    branch_at(32'h100);
    chk("lock_pc", pc, 32'h104);
    chk("lock_flag", pc_locked, 1'b1);
    pc_stall = 1; tick(); tick(); tick();
    idle(); bra_done = 1; bra_taken = 1; bra_target = 32'h203; tick(); idle();
    chk("taken_pc", pc, 32'h200);
    chk("taken_unlock", pc_locked, 1'b0);
    chk("lock_cnt4", lock_cycles, 4'd4);

    // 3: not taken, then resolution under stall
    branch_at(32'h100);
    bra_done = 1; tick(); idle();
    chk("ntaken_pc", pc, 32'h104);
    branch_at(32'h300);
    pc_stall = 1; bra_done = 1; bra_taken = 1; bra_target = 32'h500; tick(); idle();
    chk("stall_resolve_pc", pc, 32'h500);

    // 4: JAL with branch flag also set
    dec_valid = 1; dec_is_jal = 1; dec_is_branch = 1; dec_pc = 32'h40;
    dec_jal_offset = 21'h1FFFF8; tick(); idle();
    chk("jal_pc", pc, 32'h38);
    chk("jal_kill", fetch_kill, 1'b1);
    chk("jal_nolock", pc_locked, 1'b0);
    tick();
    chk("jal_kill_drop", fetch_kill, 1'b0);

    // 5: flush beats resolution in LOCK
    branch_at(32'h600);
    rob_flush = 1; rob_flush_pc = 32'h800; bra_done = 1; bra_taken = 1; bra_target = 32'h900;
    tick(); idle();
    chk("flush_pc", pc, 32'h800);
    chk("flush_kill", fetch_kill, 1'b1);
    chk("flush_err", protocol_err, 1'b0);

    // 6: protocol error, wraparound, reset in LOCK
    bra_done = 1; tick(); idle(); tick(); tick();
    chk("perr_sticky", protocol_err, 1'b1);
    rob_flush = 1; rob_flush_pc = 32'hFFFF_FFFC; tick(); idle(); tick();
    chk("wrap_pc", pc, 32'h0);
    branch_at(32'h700);
    rst = 1; tick(); idle();
    chk("rst_lock_pc", pc, 32'h0);
    chk("rst_lock_flag", pc_locked, 1'b0);
    chk("rst_perr", protocol_err, 1'b0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst            = ($urandom_range(99) < 2);
      pc_stall       = ($urandom_range(99) < 30);
      dec_valid      = ($urandom_range(99) < 60);
      dec_is_branch  = ($urandom_range(99) < 30);
      dec_is_jal     = ($urandom_range(99) < 15);
      dec_pc         = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : $urandom;
      dec_jal_offset = 21'($urandom);
      bra_done       = m_lock ? ($urandom_range(99) < 35) : ($urandom_range(99) < 2);
      bra_taken      = 1'($urandom);
      bra_target     = $urandom;
      rob_flush      = ($urandom_range(99) < 4);
      rob_flush_pc   = ($urandom_range(4) == 0) ? 32'hFFFF_FFFE : $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly upstream of the instruction cache; consumes pc_stall from the stall controller and produces pc_locked back to it.
- Holds the fetch PC and advances it by 4 per accepted fetch.
- Locks fetch after a conditional branch is decoded, until the branch unit resolves it.
- Redirects on JAL and on ROB flush, and keeps a saturating count of lock cycles for performance monitoring.

Parameters:
ADDR_WIDTH, 32, PC and target width in bits
RESET_PC, 0, PC value loaded on reset
CNT_WIDTH, 16, width of lock-cycle counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
pc_stall  input  1  from stall controller; 1 = do not advance PC this cycle
dec_valid  input  1  decoder holds a valid instruction this cycle
dec_is_branch  input  1  decoded instruction is a conditional branch
dec_is_jal  input  1  decoded instruction is JAL
dec_pc  input  ADDR_WIDTH  address of decoded instruction
dec_jal_offset  input  21  JAL immediate, signed, byte offset
bra_done  input  1  branch unit resolved the locked branch this cycle
bra_taken  input  1  resolved direction, valid with bra_done
bra_target  input  ADDR_WIDTH  taken target, valid with bra_done
rob_flush  input  1  ROB flush / exception redirect
rob_flush_pc  input  ADDR_WIDTH  restart address, valid with rob_flush
pc  output  ADDR_WIDTH  current fetch address to icache
pc_locked  output  1  1 while in LOCK state
fetch_kill  output  1  one-cycle pulse: discard instruction currently in icache/decode latch
lock_cycles  output  CNT_WIDTH  saturating count of cycles spent in LOCK
protocol_err  output  1  sticky: bra_done seen while not in LOCK

Behaviour:
- Reset values (synchronous, rst sampled at posedge):
  - state=RUN, pc=RESET_PC, pc_locked=0, fetch_kill=0, lock_cycles=0, protocol_err=0.
  - Reset mid-LOCK discards the pending fallthrough address.
- States: RUN, LOCK. pc_locked is registered and equals (state==LOCK).
- Priority each cycle, highest first: rst > rob_flush > LOCK resolution > JAL redirect > branch lock > sequential advance.
- rob_flush, any state:
  - pc <= {rob_flush_pc[ADDR_WIDTH-1:2],2'b00}; state <= RUN; fetch_kill <= 1.
  - The pending branch is dropped and pc_stall is ignored.
- RUN:
  - dec_valid & dec_is_branch & !pc_stall: fallthrough register <= dec_pc+4; pc <= dec_pc+4; state <= LOCK.
  - dec_valid & dec_is_jal & !pc_stall: pc <= dec_pc + sign_extend(dec_jal_offset), bits[1:0] forced to 00; fetch_kill <= 1; stay RUN.
  - Otherwise, !pc_stall: pc <= pc+4. pc_stall=1: pc holds.
  - dec_is_branch and dec_is_jal both set: JAL wins, no lock.
- LOCK:
  - pc holds; pc_stall is ignored.
  - bra_done=1: pc <= bra_taken ? {bra_target[ADDR_WIDTH-1:2],2'b00} : fallthrough; state <= RUN. pc_locked drops the next cycle.
  - Decoder inputs are ignored in LOCK.
  - Each cycle spent in LOCK, including the resolving cycle: lock_cycles increments, saturating at all-ones.
- fetch_kill is high for exactly one cycle after each JAL or flush event. It is not asserted on branch resolution, because fetch was already stalled.
- bra_done while state==RUN and no rob_flush this cycle: ignored for PC, protocol_err <= 1 (cleared only by rst).
- Arithmetic:
  - All PC adds are modulo 2^ADDR_WIDTH; 0xFFFFFFFC+4 = 0x00000000, no flag.
  - The JAL offset is sign-extended from bit 20 to ADDR_WIDTH.
- Latency:
  - Every redirect (flush, resolution, JAL) appears on pc the cycle after the triggering input.
  - Lock: pc_locked=1 the cycle after the branch is accepted.

Test Plan:
1. rst=1 two cycles, then pc_stall=0 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; pc_locked=0, fetch_kill=0.
2. dec_valid=1, dec_is_branch=1, dec_pc=0x100, pc_stall=0 -> next cycle pc=0x104, pc_locked=1. Hold 3 cycles, then bra_done=1, bra_taken=1, bra_target=0x203 -> pc=0x200, pc_locked=0, lock_cycles=4.
3. Same lock with bra_taken=0 -> pc=0x104 after resolution. Repeat with pc_stall=1 during resolution -> redirect still occurs.
4. JAL: dec_pc=0x40, dec_jal_offset=-8 (0x1FFFF8) -> pc=0x38, fetch_kill one-cycle pulse. Also drive dec_is_branch=1 in the same cycle -> no lock.
5. In LOCK, assert rob_flush with rob_flush_pc=0x800 and bra_done in the same cycle -> pc=0x800, state RUN, fetch_kill=1, protocol_err=0.
6. bra_done in RUN -> protocol_err=1 and stays set until rst. Also: pc=0xFFFFFFFC with pc_stall=0 -> pc wraps to 0x0. Also: rst asserted in LOCK -> pc=RESET_PC, pc_locked=0 the next cycle.
